// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word fetch at a time to instruction memory,
// buffers the returned word for decode and follows branch/jump redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic grant;
  logic handshake;
  logic capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A fetch granted or still in flight when a redirect arrives is stale and
  // must be drained before a new request goes out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ:   if (grant) state_d = redirect_valid ? DRAIN : WAIT;
      WAIT: begin
        if (imem_rvalid)         state_d = REQ;
        else if (redirect_valid) state_d = DRAIN;
      end
      DRAIN: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == REQ) && (!if_valid_q || if_ready);
    imem_addr = pc_q;
  end

  assign grant     = imem_req && imem_gnt;
  assign handshake = if_valid_q && if_ready;
  assign capture   = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q + {31'b0, handshake};
    if (handshake) begin
      if_valid_d = 1'b0;
    end
    if (capture) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rdata;
      if_pc_d    = pc_q;
      pc_d       = pc_q + 32'd4;
    end
    // Redirect wins over everything except the handshake count.
    if (redirect_valid) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'h0;
      if_pc_q       <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_opcode   = if_instr_q[6:0];
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural instruction memory feeds a
// scoreboard of expected {pc, instr} pairs that is drained on decode handshakes.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_opcode(if_opcode), .fetch_count(fetch_count)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          hsTotal = 0;
  int          memLat = 1;
  int          outLeft = 0;
  bit          outValid = 0;
  bit          outStale = 0;
  bit          respNow = 0;
  bit          staleData = 0;
  bit          lastGnt = 0;
  logic [31:0] outAddr = 32'h0;
  logic [31:0] outData = 32'h0;
  logic [63:0] sbQ[$];
  logic [31:0] grantLog[$];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  // One clock of the memory model and scoreboard; returns just after the rising edge.
  task automatic tick();
    logic        hs;
    logic        gnt;
    logic [63:0] exp;
    @(negedge clk);
    hs = if_valid && if_ready;
    vectors++;
    if (if_valid && if_instr === 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL stale_instr: if_instr=%h, required anything but DEADBEEF", if_instr);
    end
    if (hs) begin
      if (sbQ.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL unexpected_handshake: if_pc=%h, required no valid instruction", if_pc);
      end else begin
        exp = sbQ.pop_front();
        vectors += 3;
        if (if_pc !== exp[63:32]) begin
          miscompares++;
          $display("[TB] FAIL if_pc: got %h, required %h", if_pc, exp[63:32]);
        end
        if (if_instr !== exp[31:0]) begin
          miscompares++;
          $display("[TB] FAIL if_instr: got %h, required %h", if_instr, exp[31:0]);
        end
        if (if_opcode !== exp[6:0]) begin
          miscompares++;
          $display("[TB] FAIL if_opcode: got %h, required %h", if_opcode, exp[6:0]);
        end
      end
    end else if (redirect_valid && if_valid && sbQ.size() > 0) begin
      void'(sbQ.pop_front());
    end
    if (respNow) begin
      if (!outStale && !redirect_valid && reset) sbQ.push_back({outAddr, outData});
      outValid = 0;
    end else if (outValid && redirect_valid) begin
      outStale = 1;
    end
    gnt = imem_req && imem_gnt && reset;
    if (gnt) begin
      outValid  = 1;
      outStale  = redirect_valid;
      outAddr   = imem_addr;
      outData   = staleData ? 32'hDEADBEEF : memData(imem_addr);
      staleData = 0;
      outLeft   = memLat;
      grantLog.push_back(imem_addr);
    end
    lastGnt = gnt;
    @(posedge clk); #1;
    if (hs) hsTotal++;
    redirect_valid = 1'b0;
    respNow = 0;
    if (outValid) begin
      outLeft--;
      if (outLeft == 0) respNow = 1;
    end
    imem_rvalid = respNow;
    imem_rdata  = respNow ? outData : 32'h0;
    vectors++;
    if (fetch_count !== 32'(hsTotal)) begin
      miscompares++;
      $display("[TB] FAIL fetch_count: got %0d, required %0d", fetch_count, hsTotal);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors += 7;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %b, required 0", imem_req); end
    if (imem_addr !== RESET_PC) begin miscompares++; $display("[TB] FAIL rst_addr: got %h, required %h", imem_addr, RESET_PC); end
    if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b, required 0", if_valid); end
    if (if_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_instr: got %h, required 0", if_instr); end
    if (if_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_pc: got %h, required 0", if_pc); end
    if (fetch_count !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_count: got %h, required 0", fetch_count); end
    if (if_opcode !== 7'h0) begin miscompares++; $display("[TB] FAIL rst_opcode: got %h, required 0", if_opcode); end
  endtask

  task automatic test_sequential();
    int n;
    imem_gnt = 1'b1; if_ready = 1'b1; memLat = 1;
    grantLog.delete();
    reset = 1'b1;
    n = 0;
    while (grantLog.size() < 3 && n < 20) begin tick(); n++; end
    if (grantLog.size() < 3) begin
      vectors++; miscompares++;
      $display("[TB] FAIL seq_timeout: got %0d grants, required 3", grantLog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (grantLog[i] !== 32'(i * 4)) begin
          miscompares++;
          $display("[TB] FAIL seq_addr%0d: got %h, required %h", i, grantLog[i], 32'(i * 4));
        end
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_stall();
    int          n;
    logic [63:0] held;
    if_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!(if_valid === 1'b1 && !outValid) && n < 20);
    vectors++;
    if (sbQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL stall_setup: got no buffered instruction, required one");
    end else begin
      held = sbQ[0];
      grantLog.delete();
      repeat (5) begin
        tick();
        vectors += 4;
        if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_req: got %b, required 0", imem_req); end
        if (if_instr !== held[31:0]) begin miscompares++; $display("[TB] FAIL stall_instr: got %h, required %h", if_instr, held[31:0]); end
        if (if_pc !== held[63:32]) begin miscompares++; $display("[TB] FAIL stall_pc: got %h, required %h", if_pc, held[63:32]); end
        if (fetch_count !== 32'(hsTotal)) begin miscompares++; $display("[TB] FAIL stall_count: got %0d, required %0d", fetch_count, hsTotal); end
      end
      if_ready = 1'b1;
      #1;
      vectors++;
      if (imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_release_req: got %b, required 1", imem_req); end
      tick();
      vectors++;
      if (grantLog.size() != 1) begin miscompares++; $display("[TB] FAIL stall_req_count: got %0d, required 1", grantLog.size()); end
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    memLat = 3; staleData = 1;
    n = 0;
    do begin tick(); n++; end while (!lastGnt && n < 20);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    memLat = 1;
    grantLog.delete();
    #1;
    vectors += 2;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_req: got %b, required 0", imem_req); end
    if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL redirect_clear: got %b, required 0", if_valid); end
    n = 0;
    while (grantLog.size() == 0 && n < 20) begin tick(); n++; end
    vectors++;
    if (grantLog.size() == 0 || grantLog[0] !== 32'h0000_0100) begin
      miscompares++;
      $display("[TB] FAIL redirect_wait_addr: got %h, required 00000100", grantLog.size() ? grantLog[0] : 32'hX);
    end
    repeat (4) tick();
  endtask

  task automatic test_redirect_gnt();
    int n;
    memLat = 1;
    n = 0;
    #1;
    while (imem_req !== 1'b1 && n < 20) begin tick(); #1; n++; end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    grantLog.delete();
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL gnt_drain_req: got %b, required 0", imem_req); end
    n = 0;
    while (grantLog.size() == 0 && n < 20) begin tick(); n++; end
    vectors++;
    if (grantLog.size() == 0 || grantLog[0] !== 32'h0000_0200) begin
      miscompares++;
      $display("[TB] FAIL redirect_gnt_addr: got %h, required 00000200", grantLog.size() ? grantLog[0] : 32'hX);
    end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    int n;
    imem_gnt = 1'b0;
    n = 0;
    do begin tick(); #1; n++; end while (!(!outValid && imem_req === 1'b1) && n < 20);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    #1;
    vectors += 2;
    if (imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_req: got %b, required 1", imem_req); end
    if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_first: got %h, required FFFFFFFC", imem_addr); end
    grantLog.delete();
    imem_gnt = 1'b1;
    n = 0;
    while (grantLog.size() < 2 && n < 20) begin tick(); n++; end
    vectors++;
    if (grantLog.size() < 2 || grantLog[0] !== 32'hFFFF_FFFC || grantLog[1] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL wrap_addr: got %h, required 00000000", grantLog.size() > 1 ? grantLog[1] : 32'hX);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    memLat = 3;
    n = 0;
    do begin tick(); n++; end while (!lastGnt && n < 20);
    tick();
    #3;
    reset = 1'b0;
    hsTotal = 0;
    sbQ.delete();
    outStale = 1;
    #1;
    vectors += 6;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_req: got %b, required 0", imem_req); end
    if (imem_addr !== RESET_PC) begin miscompares++; $display("[TB] FAIL mid_rst_addr: got %h, required %h", imem_addr, RESET_PC); end
    if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_valid: got %b, required 0", if_valid); end
    if (if_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_instr: got %h, required 0", if_instr); end
    if (if_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_pc: got %h, required 0", if_pc); end
    if (fetch_count !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_count: got %h, required 0", fetch_count); end
    tick();
    reset = 1'b1;
    grantLog.delete();
    tick();
    vectors++;
    if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL late_rvalid: got if_valid=%b, required 0", if_valid); end
    memLat = 1;
    n = 0;
    while (grantLog.size() == 0 && n < 20) begin tick(); n++; end
    vectors++;
    if (grantLog.size() == 0 || grantLog[0] !== RESET_PC) begin
      miscompares++;
      $display("[TB] FAIL mid_rst_first_addr: got %h, required %h", grantLog.size() ? grantLog[0] : 32'hX, RESET_PC);
    end
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
